exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_unit_if.sv | 24 ++
 rtl/exec_unit.sv | 144 ++++++++++++++
 tb/tb_exec_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/exec_unit_if.sv
// Issue/writeback bundle between the decode stage, exec_unit and the register file.
interface exec_unit_if;
  logic       Start;
  logic [2:0] Op;
  logic [1:0] Rd;
  logic [7:0] OpA;
  logic [7:0] OpB;
  logic       Busy;
  logic       WbEn;
  logic [1:0] WbAddr;
  logic [7:0] WbData;
  logic       Zero;
  logic       Carry;

  modport master (
    output Start, Op, Rd, OpA, OpB,
    input  Busy, WbEn, WbAddr, WbData, Zero, Carry
  );

  modport slave (
    input  Start, Op, Rd, OpA, OpB,
    output Busy, WbEn, WbAddr, WbData, Zero, Carry
  );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: single-issue 8-bit ALU with an iterative 1-bit/cycle shifter.
// Single-cycle ops complete on the accepting edge. Shifts by k>0 spend k
// cycles in SHIFT. All results are written back from DONE.
module exec_unit (
  input  logic        Clk,
  input  logic        Reset,
  exec_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  state_t     state_q, state_d;
  logic       dir_q;          // 0: shift left, 1: shift right
  logic [1:0] rd_q;
  logic [7:0] sh_q;
  logic [2:0] cnt_q;

  logic       wb_en_q;
  logic [1:0] wb_addr_q;
  logic [7:0] wb_data_q;
  logic       zero_q;
  logic       carry_q;

  logic       accept;
  logic       is_shift;
  logic [2:0] k;
  logic [8:0] sum9;
  logic [7:0] imm_r;
  logic       imm_c;
  logic [7:0] sh_nx;
  logic       sh_out;

  // Start is dropped while iterating; shift opcodes are 10x.
  assign accept   = bus.Start && (state_q != SHIFT);
  assign is_shift = (bus.Op[2:1] == 2'b10);
  assign k        = bus.OpB[2:0];

  // Single-cycle result straight from the issue inputs (also covers k=0 shifts).
  always_comb begin
    sum9  = {1'b0, bus.OpA} + {1'b0, bus.OpB};
    imm_r = bus.OpA;
    imm_c = 1'b0;
    case (bus.Op)
      OP_ADD: begin
        imm_r = sum9[7:0];
        imm_c = sum9[8];
      end
      OP_SUB, OP_CMP: begin
        imm_r = bus.OpA - bus.OpB;
        imm_c = (bus.OpA < bus.OpB);
      end
      OP_AND:  imm_r = bus.OpA & bus.OpB;
      OP_XOR:  imm_r = bus.OpA ^ bus.OpB;
      OP_MOV:  imm_r = bus.OpB;
      default: imm_r = bus.OpA;
    endcase
  end

  // One-bit shift step of the captured operand, zero-filled.
  always_comb begin
    sh_nx  = {sh_q[6:0], 1'b0};
    sh_out = sh_q[7];
    if (dir_q) begin
      sh_nx  = {1'b0, sh_q[7:1]};
      sh_out = sh_q[0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept)
          state_d = (is_shift && (k != 3'd0)) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt_q == 3'd1)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand capture, shift iteration and registered writeback/flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      rd_q      <= 2'd0;
      sh_q      <= 8'd0;
      cnt_q     <= 3'd0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= 2'd0;
      wb_data_q <= 8'd0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wb_en_q <= 1'b0;
      if (accept) begin
        dir_q <= bus.Op[0];
        rd_q  <= bus.Rd;
        sh_q  <= bus.OpA;
        cnt_q <= k;
        if (state_d == DONE) begin
          zero_q  <= (imm_r == 8'd0);
          carry_q <= imm_c;
          if (bus.Op != OP_CMP) begin
            wb_en_q   <= 1'b1;
            wb_addr_q <= bus.Rd;
            wb_data_q <= imm_r;
          end
        end
      end else if (state_q == SHIFT) begin
        sh_q  <= sh_nx;
        cnt_q <= cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          zero_q    <= (sh_nx == 8'd0);
          carry_q   <= sh_out;
          wb_en_q   <= 1'b1;
          wb_addr_q <= rd_q;
          wb_data_q <= sh_nx;
        end
      end
    end
  end

  assign bus.Busy   = (state_q == SHIFT);
  assign bus.WbEn   = wb_en_q;
  assign bus.WbAddr = wb_addr_q;
  assign bus.WbData = wb_data_q;
  assign bus.Zero   = zero_q;
  assign bus.Carry  = carry_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: table of single-cycle ops plus hand-written
// sequences for shifting, back-to-back issue and reset mid-shift.
module tb_exec_unit;

  logic Clk;
  logic Reset;
  exec_unit_if bus ();

  exec_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd;
    logic [7:0] a;
    logic [7:0] b;
    logic       en;
    logic [1:0] addr;
    logic [7:0] data;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vecs [10];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one issue strobe across a single rising edge; returns #1 after it.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd,
                       input logic [7:0] a, input logic [7:0] b);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.Rd    = rd;
    bus.OpA   = a;
    bus.OpB   = b;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic busy, input logic en,
                         input logic [1:0] addr, input logic [7:0] data,
                         input logic z, input logic c);
    chk({tag, ".Busy"},   32'(bus.Busy),   32'(busy));
    chk({tag, ".WbEn"},   32'(bus.WbEn),   32'(en));
    chk({tag, ".WbAddr"}, 32'(bus.WbAddr), 32'(addr));
    chk({tag, ".WbData"}, 32'(bus.WbData), 32'(data));
    chk({tag, ".Zero"},   32'(bus.Zero),   32'(z));
    chk({tag, ".Carry"},  32'(bus.Carry),  32'(c));
  endtask

  initial begin
    //           op     rd    a      b      en    addr  data   z     c
    vecs[0] = '{3'd0, 2'd2, 8'hF0, 8'h20, 1'b1, 2'd2, 8'h10, 1'b0, 1'b1}; // ADD carry out
    vecs[1] = '{3'd7, 2'd3, 8'h05, 8'h05, 1'b0, 2'd2, 8'h10, 1'b1, 1'b0}; // CMP equal, no wb
    vecs[2] = '{3'd1, 2'd1, 8'h03, 8'h05, 1'b1, 2'd1, 8'hFE, 1'b0, 1'b1}; // SUB borrow
    vecs[3] = '{3'd2, 2'd0, 8'hF0, 8'h0F, 1'b1, 2'd0, 8'h00, 1'b1, 1'b0}; // AND -> 0
    vecs[4] = '{3'd3, 2'd3, 8'hFF, 8'h0F, 1'b1, 2'd3, 8'hF0, 1'b0, 1'b0}; // XOR
    vecs[5] = '{3'd6, 2'd2, 8'h00, 8'h5A, 1'b1, 2'd2, 8'h5A, 1'b0, 1'b0}; // MOV
    vecs[6] = '{3'd5, 2'd1, 8'h01, 8'h00, 1'b1, 2'd1, 8'h01, 1'b0, 1'b0}; // SHR k=0
    vecs[7] = '{3'd0, 2'd0, 8'hFF, 8'h01, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1}; // ADD wrap to 0
    vecs[8] = '{3'd4, 2'd3, 8'h80, 8'h08, 1'b1, 2'd3, 8'h80, 1'b0, 1'b0}; // SHL k=B[2:0]=0
    vecs[9] = '{3'd7, 2'd0, 8'h03, 8'h05, 1'b0, 2'd3, 8'h80, 1'b0, 1'b1}; // CMP borrow, holds

    bus.Start = 1'b0;
    bus.Op    = 3'd0;
    bus.Rd    = 2'd0;
    bus.OpA   = 8'd0;
    bus.OpB   = 8'd0;
    Reset     = 1'b1;
    step();
    step();
    chk_all("reset", 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;

    // Single-cycle ops: result one edge after acceptance, then back to idle.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].rd, vecs[i].a, vecs[i].b);
      chk_all($sformatf("vec%0d", i), 1'b0, vecs[i].en, vecs[i].addr,
              vecs[i].data, vecs[i].z, vecs[i].c);
      step();
      chk($sformatf("vec%0d.idle_WbEn", i), 32'(bus.WbEn), 32'd0);
    end

    // SHL 0x81 by 3: three Busy cycles, Start during Busy is dropped.
    issue(3'd4, 2'd1, 8'h81, 8'h03);
    chk_all("shl.c1", 1'b1, 1'b0, 2'd3, 8'h80, 1'b0, 1'b1);
    issue(3'd0, 2'd0, 8'h11, 8'h22);
    chk("shl.c2.Busy", 32'(bus.Busy), 32'd1);
    chk("shl.c2.WbEn", 32'(bus.WbEn), 32'd0);
    step();
    chk("shl.c3.Busy", 32'(bus.Busy), 32'd1);
    chk("shl.c3.WbEn", 32'(bus.WbEn), 32'd0);
    step();
    chk_all("shl.done", 1'b0, 1'b1, 2'd1, 8'h08, 1'b0, 1'b0);
    step();
    chk_all("shl.after", 1'b0, 1'b0, 2'd1, 8'h08, 1'b0, 1'b0);

    // Back-to-back issue from DONE: XOR then MOV 0 on consecutive cycles.
    issue(3'd3, 2'd2, 8'hFF, 8'h0F);
    chk_all("b2b.xor", 1'b0, 1'b1, 2'd2, 8'hF0, 1'b0, 1'b0);
    issue(3'd6, 2'd0, 8'h77, 8'h00);
    chk_all("b2b.mov", 1'b0, 1'b1, 2'd0, 8'h00, 1'b1, 1'b0);

    // Leave nonzero outputs, then reset in the 2nd SHIFT cycle of SHL by 5.
    issue(3'd0, 2'd3, 8'hFF, 8'hFF);
    chk_all("pre_rst", 1'b0, 1'b1, 2'd3, 8'hFE, 1'b0, 1'b1);
    issue(3'd4, 2'd1, 8'hFF, 8'h05);
    chk("rst.shift1.Busy", 32'(bus.Busy), 32'd1);
    step();
    chk("rst.shift2.Busy", 32'(bus.Busy), 32'd1);
    Reset = 1'b1;
    step();
    chk_all("rst.abort", 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rst.nowb%0d", i), 32'({bus.Busy, bus.WbEn}), 32'd0);
    end

    // Operation resumes right after reset.
    issue(3'd0, 2'd1, 8'h01, 8'h02);
    chk_all("resume", 1'b0, 1'b1, 2'd1, 8'h03, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
